pipeline_hazard_unit: RTL and testbench

//  Parametrised hazard and forwarding controller for the pipelined RV32I core; sits beside the decode stage.

---
 rtl/pipeline_hazard_unit.sv | 70 +++++++
 tb/tb_pipeline_hazard_unit.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_hazard_unit.sv
// pipeline_hazard_unit: tracks in-flight register writes after decode, raising load-use stalls
// and selecting which post-decode stage forwards each source operand.
module pipeline_hazard_unit #(
    parameter int STAGES = 3,
    parameter int IDX_W = 5,
    parameter int READ_PORTS = 2,
    parameter int LOAD_READY = 2,
    parameter int CNT_W = 32,
    localparam int SEL_W = $clog2(STAGES + 1)
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        ext_stall,
    input  logic                        jump_enable,
    input  logic                        issue_valid,
    input  logic [IDX_W-1:0]            issue_rd_idx,
    input  logic                        issue_reg_write,
    input  logic                        issue_mem_load,
    input  logic [READ_PORTS*IDX_W-1:0] rs_idx,
    input  logic [READ_PORTS-1:0]       rs_used,
    output logic                        stall,
    output logic [READ_PORTS*SEL_W-1:0] fwd_sel,
    output logic [CNT_W-1:0]            stall_count,
    output logic [CNT_W-1:0]            fwd_count
);
    logic [STAGES:1]     r_valid;
    logic [STAGES:1]     r_load;
    logic [IDX_W-1:0]    r_rd [1:STAGES];
    logic [CNT_W-1:0]    r_stall_cnt;
    logic [CNT_W-1:0]    r_fwd_cnt;
    logic [READ_PORTS-1:0] w_haz;
    logic                w_ins;

    // Scan oldest to youngest so the youngest match overwrites older ones.
    always_comb begin
        w_haz = '0;
        fwd_sel = '0;
        for (int p = 0; p < READ_PORTS; p++) begin
            for (int k = STAGES; k >= 1; k--) begin
                if (rs_used[p] && issue_valid && r_valid[k] &&
                    r_rd[k] == rs_idx[p*IDX_W +: IDX_W] && rs_idx[p*IDX_W +: IDX_W] != '0) begin
                    w_haz[p] = r_load[k] && (k < LOAD_READY);
                    fwd_sel[p*SEL_W +: SEL_W] = (r_load[k] && (k < LOAD_READY)) ? '0 : SEL_W'(k);
                end
            end
        end
        stall = |w_haz && !jump_enable;
        w_ins = issue_valid && issue_reg_write && !stall && !jump_enable;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_valid <= '0;
            r_load <= '0;
            for (int k = 1; k <= STAGES; k++) r_rd[k] <= '0;
            r_stall_cnt <= '0;
            r_fwd_cnt <= '0;
        end else if (!ext_stall) begin
            r_valid <= {r_valid[STAGES-1:1], w_ins};
            r_load <= {r_load[STAGES-1:1], issue_mem_load};
            r_rd[1] <= issue_rd_idx;
            for (int k = 2; k <= STAGES; k++) r_rd[k] <= r_rd[k-1];
            if (stall && !(&r_stall_cnt)) r_stall_cnt <= r_stall_cnt + 1'b1;
            if (|fwd_sel && !(&r_fwd_cnt)) r_fwd_cnt <= r_fwd_cnt + 1'b1;
        end
    end

    assign stall_count = r_stall_cnt;
    assign fwd_count = r_fwd_cnt;
endmodule

// File: tb/tb_pipeline_hazard_unit.sv
// tb_pipeline_hazard_unit: directed and random stimulus against a queue-based model of
// the in-flight writes; a second instance with 3-bit counters exercises saturation.
module tb_pipeline_hazard_unit;
    localparam int S = 3, IW = 5, RP = 2, LR = 2, SW = 2;

    logic clk = 0;
    logic reset, ext_stall, jump_enable, issue_valid, issue_reg_write, issue_mem_load;
    logic [IW-1:0] issue_rd_idx;
    logic [RP*IW-1:0] rs_idx;
    logic [RP-1:0] rs_used;
    logic stall, s_stall;
    logic [RP*SW-1:0] fwd_sel, s_fwd;
    logic [31:0] stall_count, fwd_count;
    logic [2:0] s_stall_count, s_fwd_count;

    pipeline_hazard_unit dut (
        .clk(clk), .reset(reset), .ext_stall(ext_stall), .jump_enable(jump_enable),
        .issue_valid(issue_valid), .issue_rd_idx(issue_rd_idx), .issue_reg_write(issue_reg_write),
        .issue_mem_load(issue_mem_load), .rs_idx(rs_idx), .rs_used(rs_used),
        .stall(stall), .fwd_sel(fwd_sel), .stall_count(stall_count), .fwd_count(fwd_count)
    );

    pipeline_hazard_unit #(.CNT_W(3)) u_sat (
        .clk(clk), .reset(reset), .ext_stall(ext_stall), .jump_enable(jump_enable),
        .issue_valid(issue_valid), .issue_rd_idx(issue_rd_idx), .issue_reg_write(issue_reg_write),
        .issue_mem_load(issue_mem_load), .rs_idx(rs_idx), .rs_used(rs_used),
        .stall(s_stall), .fwd_sel(s_fwd), .stall_count(s_stall_count), .fwd_count(s_fwd_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit v;
        int rd;
        bit ld;
    } ent_t;

    ent_t pipe[$];
    longint m_sc, m_fc;
    int checks, fails;
    bit e_stall;
    int e_sel[RP];

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s got=%0d exp=%0d at %0t", tag, act, exp, $time);
        end
    endtask

    function automatic longint sat7(input longint x);
        return x > 7 ? 7 : x;
    endfunction

    task automatic model_reset();
        ent_t b;
        b.v = 0; b.rd = 0; b.ld = 0;
        pipe.delete();
        repeat (S) pipe.push_back(b);
        m_sc = 0;
        m_fc = 0;
    endtask

    // Expected outputs: first (youngest) in-flight writer of each read source decides.
    task automatic predict();
        e_stall = 0;
        for (int p = 0; p < RP; p++) begin
            int rs;
            e_sel[p] = 0;
            rs = int'(rs_idx[p*IW +: IW]);
            if (issue_valid && rs_used[p] && rs != 0) begin
                for (int k = 0; k < S; k++) begin
                    if (pipe[k].v && pipe[k].rd == rs) begin
                        if (pipe[k].ld && k + 1 < LR) e_stall = 1;
                        else e_sel[p] = k + 1;
                        break;
                    end
                end
            end
        end
        if (jump_enable) e_stall = 0;
    endtask

    task automatic drive(input bit v, input int rd, input bit wr, input bit ld,
                         input int r0, input int r1, input bit [1:0] used,
                         input bit ext, input bit jmp);
        issue_valid = v; issue_rd_idx = IW'(rd); issue_reg_write = wr; issue_mem_load = ld;
        rs_idx = {IW'(r1), IW'(r0)}; rs_used = used; ext_stall = ext; jump_enable = jmp;
    endtask

    // Compare mid-low-phase, then clock once and advance the model.
    task automatic tick();
        ent_t n;
        bit any;
        #1;
        predict();
        chk("stall", stall, e_stall);
        chk("sat_stall", s_stall, e_stall);
        any = 0;
        for (int p = 0; p < RP; p++) begin
            chk($sformatf("fwd%0d", p), fwd_sel[p*SW +: SW], e_sel[p]);
            if (e_sel[p] != 0) any = 1;
        end
        chk("stall_count", stall_count, m_sc);
        chk("fwd_count", fwd_count, m_fc);
        chk("sat_stall_count", s_stall_count, sat7(m_sc));
        chk("sat_fwd_count", s_fwd_count, sat7(m_fc));
        @(posedge clk);
        if (!ext_stall) begin
            n.v = issue_valid && issue_reg_write && !e_stall && !jump_enable;
            n.rd = int'(issue_rd_idx);
            n.ld = issue_mem_load;
            void'(pipe.pop_back());
            pipe.push_front(n);
            if (e_stall) m_sc++;
            if (any) m_fc++;
        end
        @(negedge clk);
    endtask

    task automatic idle();
        drive(0, 0, 0, 0, 0, 0, 2'b00, 0, 0);
    endtask

    initial begin
        checks = 0; fails = 0;
        idle();
        reset = 1;
        model_reset();
        repeat (2) @(negedge clk);
        chk("reset_stall", stall, 0);
        chk("reset_fwd", fwd_sel, 0);
        chk("reset_sc", stall_count, 0);
        reset = 0;

        // add x5 ; add x6,x5,x1
        drive(1, 5, 1, 0, 0, 0, 2'b00, 0, 0); tick();
        drive(1, 6, 1, 0, 5, 1, 2'b11, 0, 0); #1;
        chk("alu_fwd0", fwd_sel[1:0], 1);
        chk("alu_fwd1", fwd_sel[3:2], 0);
        tick();
        idle(); tick(); tick(); tick();

        // lw x5 ; add x6,x5,x5 : one stall then forward from stage 2
        drive(1, 5, 1, 1, 0, 0, 2'b00, 0, 0); tick();
        drive(1, 6, 1, 0, 5, 5, 2'b11, 0, 0); #1;
        chk("lu_stall", stall, 1);
        chk("lu_fwd", fwd_sel, 0);
        tick(); #1;
        chk("lu_stall2", stall, 0);
        chk("lu_fwd2", fwd_sel, {2'd2, 2'd2});
        tick();
        idle(); tick(); tick(); tick();

        // x7 at stages 1 and 3; x0 never forwards
        drive(1, 7, 1, 0, 0, 0, 2'b00, 0, 0); tick();
        drive(1, 0, 1, 0, 0, 0, 2'b00, 0, 0); tick();
        drive(1, 7, 1, 0, 0, 0, 2'b00, 0, 0); tick();
        drive(1, 9, 1, 0, 7, 0, 2'b11, 0, 0); #1;
        chk("young_fwd", fwd_sel[1:0], 1);
        chk("x0_fwd", fwd_sel[3:2], 0);
        tick();
        idle(); tick(); tick(); tick();

        // lw x5 then jump with a reader: flush wins
        drive(1, 5, 1, 1, 0, 0, 2'b00, 0, 0); tick();
        drive(1, 8, 1, 0, 5, 0, 2'b01, 0, 1); #1;
        chk("jmp_stall", stall, 0);
        tick();
        drive(1, 10, 1, 0, 8, 5, 2'b11, 0, 0); tick();
        idle(); tick(); tick(); tick();

        // load-use frozen by ext_stall for 4 cycles
        drive(1, 5, 1, 1, 0, 0, 2'b00, 0, 0); tick();
        drive(1, 6, 1, 0, 5, 0, 2'b01, 1, 0);
        repeat (4) tick();
        drive(1, 6, 1, 0, 5, 0, 2'b01, 0, 0); tick(); tick();
        idle(); tick(); tick(); tick();

        // random traffic, small register range for frequent collisions
        for (int i = 0; i < 600; i++) begin
            drive($urandom_range(7) != 0, $urandom_range(7), $urandom_range(3) != 0,
                  $urandom_range(2) == 0, $urandom_range(7), $urandom_range(7),
                  2'($urandom_range(3)), $urandom_range(7) == 0, $urandom_range(9) == 0);
            tick();
        end

        // async reset during a stall with a full table
        drive(1, 3, 1, 0, 0, 0, 2'b00, 0, 0); tick();
        drive(1, 4, 1, 0, 0, 0, 2'b00, 0, 0); tick();
        drive(1, 5, 1, 1, 0, 0, 2'b00, 0, 0); tick();
        drive(1, 6, 1, 0, 5, 4, 2'b11, 0, 0); #1;
        chk("pre_rst_stall", stall, 1);
        #1 reset = 1; #1;
        chk("async_stall", stall, 0);
        chk("async_fwd", fwd_sel, 0);
        chk("async_sc", stall_count, 0);
        chk("async_fc", fwd_count, 0);
        model_reset();
        @(negedge clk);
        reset = 0;
        tick();
        idle(); tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end
endmodule
